// File: rtl/if_fetch_stage_pkg.sv
// Fetch-stage types, constants and helpers.
// Imported by the fetch stage and its queue.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0060;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pcmux_mp4.sv
// PC-mux select encoding shared by EX and fetch.
// Only the three listed codes are legal.
package pcmux_mp4;

  typedef enum logic [1:0] {
    pc_plus4   = 2'b00,
    branch_jal = 2'b01,
    jalr       = 2'b10
  } pcmux_mp4_sel_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response port.
// master = fetch stage, slave = memory.
interface if_fetch_stage_if;

  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_rdata,
    input  imem_resp
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_rdata,
    output imem_resp
  );

endinterface

// File: rtl/if_fetch_stage_queue.sv
// Small synchronous FIFO holding fetched {pc, instr}.
// Head is read straight from storage registers.
module fetch_queue #(
  parameter int unsigned W = 64,
  parameter int unsigned DEPTH = 2,
  parameter logic [W-1:0] RST_DATA = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       head_valid,
  output logic [W-1:0]               head_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != FULL) || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < int'(DEPTH); i++)
        mem[i] <= RST_DATA;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push)
                 - (AW+1)'(do_pop);
    end
  end

  assign count      = cnt;
  assign head_valid = (cnt != '0);
  assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_stage.sv
// RV32I fetch stage: PC redirect, imem request FSM,
// stale-response drop and fetch queue toward ID.
module if_fetch_stage
  import pcmux_mp4::*;
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  pcmux_mp4_sel_t           pcmux_sel,
  input  logic [31:0]              branch_target,
  input  logic [31:0]              jalr_target,
  input  logic                     id_stall,
  if_fetch_stage_if.master         imem,
  output logic                     if_valid,
  output logic [31:0]              if_pc,
  output logic [31:0]              if_instr
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(QDEPTH);

  fetch_state_t state;
  fetch_state_t state_n;
  logic [31:0]  fetch_pc;
  logic [31:0]  fetch_pc_n;
  logic [31:0]  addr_q;
  logic [31:0]  addr_n;
  logic         read_q;
  logic         read_n;
  logic [31:0]  target;
  logic [31:0]  pc_inc;
  logic         redirect;
  logic         push;
  logic         pop;
  logic [CW-1:0] count;
  logic [CW:0]  count_x;
  logic [CW:0]  fill_after;
  fetch_entry_t push_data;
  fetch_entry_t head;

  assign redirect = (pcmux_sel == branch_jal)
                 || (pcmux_sel == jalr);

  // word_align also clears jalr bit 0
  always_comb begin
    unique case (1'b1)
      (pcmux_sel == jalr):
        target = word_align(jalr_target);
      default:
        target = word_align(branch_target);
    endcase
  end

  assign pc_inc     = fetch_pc + 32'd4;
  assign pop        = if_valid && !id_stall;
  assign count_x    = {1'b0, count};
  assign fill_after = count_x + (CW+1)'(1)
                    - (CW+1)'(pop);
  assign push_data  = '{pc: fetch_pc,
                        instr: imem.imem_rdata};

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    read_n     = read_q;
    addr_n     = addr_q;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_n = target;
        end else if (count_x < DEPTH_C) begin
          state_n = BUSY;
          read_n  = 1'b1;
          addr_n  = fetch_pc;
        end
      end
      BUSY: begin
        if (imem.imem_resp && redirect) begin
          fetch_pc_n = target;
          read_n     = 1'b0;
          state_n    = IDLE;
        end else if (imem.imem_resp) begin
          push       = 1'b1;
          fetch_pc_n = pc_inc;
          if (fill_after < DEPTH_C) begin
            addr_n = pc_inc;
          end else begin
            read_n  = 1'b0;
            state_n = IDLE;
          end
        end else if (redirect) begin
          fetch_pc_n = target;
          state_n    = DROP;
        end
      end
      DROP: begin
        // request must stay asserted until memory answers
        if (redirect)
          fetch_pc_n = target;
        if (imem.imem_resp) begin
          read_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      read_q   <= 1'b0;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      read_q   <= read_n;
      addr_q   <= addr_n;
    end
  end

  assign imem.imem_read    = read_q;
  assign imem.imem_address = addr_q;

  fetch_queue #(
    .W        (64),
    .DEPTH    (QDEPTH),
    .RST_DATA ({32'h0, NOP_INSTR})
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .flush      (redirect),
    .count      (count),
    .head_valid (if_valid),
    .head_data  (head)
  );

  assign if_pc    = head.pc;
  assign if_instr = head.instr;

  always @(posedge clk)
    if (rst)
      assert (pcmux_sel != 2'b11)
        else $error("illegal pcmux_sel 2'b11");

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: memory model with scoreboard,
// redirect vector table and hand-written corner sequences.
module tb_if_fetch_stage;
  import pcmux_mp4::*;
  import if_fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h4000_0060;

  typedef struct {
    pcmux_mp4_sel_t sel;
    logic [31:0]    bt;
    logic [31:0]    jt;
    logic [31:0]    exp;
  } redir_vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  pcmux_mp4_sel_t pcmux_sel = pc_plus4;
  logic [31:0]    branch_target = '0;
  logic [31:0]    jalr_target = '0;
  logic           id_stall = 1'b0;
  logic           if_valid;
  logic [31:0]    if_pc;
  logic [31:0]    if_instr;

  if_fetch_stage_if bus ();

  if_fetch_stage #(
    .RESET_PC (RPC),
    .QDEPTH   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pcmux_sel     (pcmux_sel),
    .branch_target (branch_target),
    .jalr_target   (jalr_target),
    .id_stall      (id_stall),
    .imem          (bus.master),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          mem_lat = 1;
  int          wcnt = 0;
  int          n_resp = 0;
  int          n_deliv = 0;
  logic        late_resp = 1'b0;
  logic [31:0] next_exp_addr = RPC;
  logic        drop_next = 1'b0;
  logic [31:0] drop_target = '0;
  logic [31:0] exp_out [$];
  redir_vec_t  vecs [6];

  function automatic logic [31:0] instr_of(
    input logic [31:0] a
  );
    return a ^ 32'h5A3C_0F01;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // ID-side scoreboard and imem model, sampled at negedge+1
  always @(negedge clk) begin
    logic [31:0] e;
    #1;
    if (rst && if_valid && !id_stall) begin
      if (exp_out.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_deliver: got pc %h expected none",
                 if_pc);
      end else begin
        e = exp_out.pop_front();
        check("deliver_pc", if_pc, e);
        check("deliver_instr", if_instr, instr_of(e));
        n_deliv++;
      end
    end
    if (!rst) begin
      wcnt = 0;
      bus.imem_resp  = late_resp;
      bus.imem_rdata = 32'hBAD0_BAD0;
    end else if (bus.imem_resp) begin
      bus.imem_resp = 1'b0;
      wcnt = 0;
    end else if (bus.imem_read) begin
      wcnt++;
      if (wcnt >= mem_lat) begin
        bus.imem_resp  = 1'b1;
        bus.imem_rdata = instr_of(bus.imem_address);
        n_resp++;
        check("req_addr", bus.imem_address, next_exp_addr);
        if (drop_next) begin
          drop_next = 1'b0;
          next_exp_addr = drop_target;
        end else begin
          exp_out.push_back(next_exp_addr);
          next_exp_addr = next_exp_addr + 32'd4;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_read"}, 32'(bus.imem_read), 32'd0);
    check({tag, "_imem_addr"}, bus.imem_address, RPC);
    check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_if_pc"}, if_pc, 32'h0);
    check({tag, "_if_instr"}, if_instr, NOP_INSTR);
  endtask

  task automatic wait_deliv(input int n, input int max,
                            input string name);
    int target;
    bit done;
    target = n_deliv + n;
    done = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      #2;
      if (n_deliv >= target) begin
        done = 1'b1;
        break;
      end
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input int max, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      #2;
      if (if_valid) begin
        done = 1'b1;
        break;
      end
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic quiesce(input string name);
    bit done;
    done = 1'b0;
    @(negedge clk);
    id_stall = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #2;
      if (!bus.imem_read && if_valid
          && exp_out.size() == 2) begin
        done = 1'b1;
        break;
      end
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    id_stall = 1'b0;
    pcmux_sel = pc_plus4;
    exp_out.delete();
    next_exp_addr = RPC;
    drop_next = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    vecs[0] = '{branch_jal, 32'h4000_1000, 32'h0,
                32'h4000_1000};
    vecs[1] = '{jalr, 32'h0, 32'h4000_2003,
                32'h4000_2000};
    vecs[2] = '{branch_jal, 32'h4000_3002, 32'hDEAD_BEEF,
                32'h4000_3000};
    vecs[3] = '{jalr, 32'h4000_5000, 32'h1234_5679,
                32'h1234_5678};
    vecs[4] = '{branch_jal, 32'hFFFF_FFFC, 32'h0,
                32'hFFFF_FFFC};
    vecs[5] = '{jalr, 32'h0, 32'h0000_0101,
                32'h0000_0100};

    #1 rst = 1'b0;
    #2 check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // 1-cycle memory, no stall: 60, 64, 68, ...
    mem_lat = 1;
    wait_deliv(6, 40, "basic_deliver");

    // hold stall six cycles
    begin
      int r0;
      @(negedge clk);
      id_stall = 1'b1;
      r0 = n_resp;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        #2;
        if (if_valid && exp_out.size() > 0)
          check("stall_hold_pc", if_pc, exp_out[0]);
      end
      check("stall_resp_bound",
            32'((n_resp - r0) <= 2), 32'd1);
      check("stall_read_low", 32'(bus.imem_read), 32'd0);
      @(negedge clk);
      id_stall = 1'b0;
      wait_deliv(4, 40, "resume_deliver");
    end

    // redirect vectors applied from a full, idle queue
    foreach (vecs[k]) begin
      quiesce("quiesce");
      @(negedge clk);
      pcmux_sel     = vecs[k].sel;
      branch_target = vecs[k].bt;
      jalr_target   = vecs[k].jt;
      exp_out.delete();
      next_exp_addr = vecs[k].exp;
      @(negedge clk);
      pcmux_sel = pc_plus4;
      id_stall  = 1'b0;
      #2 check("flush_valid", 32'(if_valid), 32'd0);
      wait_valid(20, "redir_valid");
      check("redir_first_pc", if_pc, vecs[k].exp);
      wait_deliv(3, 30, "redir_deliver");
    end

    // branch while a 3-cycle request to 4000_0070 is pending
    do_reset();
    mem_lat = 3;
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 80; i++) begin
        @(negedge clk);
        #2;
        if (bus.imem_read && !bus.imem_resp
            && bus.imem_address == 32'h4000_0070) begin
          found = 1'b1;
          break;
        end
      end
      check("find_0070", 32'(found), 32'd1);
      branch_target = 32'h4000_1000;
      pcmux_sel     = branch_jal;
      drop_next     = 1'b1;
      drop_target   = 32'h4000_1000;
      exp_out.delete();
      @(negedge clk);
      pcmux_sel = pc_plus4;
      for (int i = 0; i < 2; i++) begin
        #2;
        check("drop_hold_read", 32'(bus.imem_read), 32'd1);
        check("drop_hold_addr", bus.imem_address,
              32'h4000_0070);
        @(negedge clk);
      end
      wait_valid(30, "drop_valid");
      check("drop_first_pc", if_pc, 32'h4000_1000);
      wait_deliv(2, 40, "drop_deliver");
    end

    // jalr arriving with a response on the same edge
    mem_lat = 1;
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        #2;
        if (bus.imem_resp) begin
          found = 1'b1;
          break;
        end
      end
      check("find_resp", 32'(found), 32'd1);
      jalr_target = 32'h4000_2003;
      pcmux_sel   = jalr;
      exp_out.delete();
      next_exp_addr = 32'h4000_2000;
      drop_next = 1'b0;
      @(negedge clk);
      pcmux_sel = pc_plus4;
      wait_valid(20, "coinc_valid");
      check("coinc_first_pc", if_pc, 32'h4000_2000);
      check("coinc_first_instr", if_instr,
            instr_of(32'h4000_2000));
      wait_deliv(2, 30, "coinc_deliver");
    end

    // asynchronous reset while a request is outstanding
    mem_lat = 3;
    begin
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        #2;
        if (bus.imem_read && !bus.imem_resp) begin
          found = 1'b1;
          break;
        end
      end
      check("find_busy", 32'(found), 32'd1);
      rst = 1'b0;
      #1 check_reset_outputs("async_rst");
      exp_out.delete();
      next_exp_addr = RPC;
      drop_next = 1'b0;
      late_resp = 1'b1;
      @(negedge clk);
      @(negedge clk);
      late_resp = 1'b0;
      #2 check("late_resp_valid", 32'(if_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      mem_lat = 1;
      wait_valid(20, "post_rst_valid");
      check("post_rst_first_pc", if_pc, RPC);
      wait_deliv(3, 30, "post_rst_deliver");
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    checks++;
    failures++;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Pipelined RV32I instruction-fetch stage, directly upstream of decode.
- Consumes the EX-stage PC redirect (pcmux_mp4_sel_t plus targets) and drives the instruction-memory port.
- Buffers returned instructions in a small FIFO and presents {pc, instr} to ID under a valid/stall handshake.
- Discards in-flight responses that a branch or jump has made stale.

Parameters:
- RESET_PC, 32'h4000_0060, first fetch address after reset.
- QDEPTH, 2, fetch-queue entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pcmux_sel  in  2  pcmux_mp4::pcmux_mp4_sel_t from EX; pc_plus4 means no redirect.
- branch_target  in  32  target used when pcmux_sel == branch_jal.
- jalr_target  in  32  target used when pcmux_sel == jalr; bit 0 is cleared before use.
- id_stall  in  1  ID cannot accept this cycle (hazard unit).
- imem_read  out  1  request strobe, held high until imem_resp.
- imem_address  out  32  fetch address, word-aligned, stable while imem_read is high.
- imem_rdata  in  32  instruction word, valid with imem_resp.
- imem_resp  in  1  one-cycle response pulse.
- if_valid  out  1  queue head is valid.
- if_pc  out  32  PC of the queue head.
- if_instr  out  32  instruction of the queue head.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC; queue empty; state=IDLE.
  - imem_read=0, imem_address=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP).
- Reset mid-request: the outstanding request is abandoned; any imem_resp while rst=0 is ignored.
- States:
  - IDLE: no request outstanding.
  - BUSY: request outstanding.
  - DROP: outstanding request is stale; its response is discarded.
- IDLE -> BUSY when the queue has a free slot (count < QDEPTH) and no redirect this cycle. imem_read=1 and imem_address=fetch_pc are registered outputs, asserted the cycle after the decision.
- BUSY with imem_resp:
  - Enqueue {fetch_pc, imem_rdata}; fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
  - Stay in BUSY and issue the next address the following cycle if a slot will remain; otherwise go to IDLE.
- Redirect (pcmux_sel is branch_jal or jalr; single-cycle pulse):
  - fetch_pc <= selected target with bits [1:0] forced to 0.
  - Queue is flushed the same edge; if_valid=0 next cycle.
  - BUSY with no resp this cycle -> DROP; keep imem_read/imem_address unchanged until imem_resp (the memory protocol requires this), discard the data, then -> IDLE.
  - BUSY with resp in the same cycle -> the response is discarded -> IDLE.
  - IDLE -> stays IDLE and issues the target next cycle.
  - Redirect while already in DROP -> stay in DROP and update fetch_pc to the newest target.
- pcmux_sel == 2'b11 is illegal; it is treated as pc_plus4. A simulation assertion flags it.
- Dequeue when if_valid && !id_stall.
- Enqueue and dequeue in the same cycle: count unchanged.
- Full queue: no new request is issued. A request already outstanding is always accepted, because issue is gated by count + outstanding < QDEPTH.
- Latency:
  - imem_resp at edge N -> if_valid at N+1 if the queue was empty (registered queue head).
  - Steady-state throughput: 1 instruction per 2 cycles minimum with single-cycle memory. Back-to-back requests are permitted when a slot exists.
- Outputs hold their values when id_stall=1.

Decomposition:
- Reuse package pcmux_mp4 (pcmux_mp4_sel_t). Add package if_fetch_pkg with:
  - fetch_state_t {IDLE, BUSY, DROP};
  - RESET_PC_DEFAULT;
  - NOP_INSTR = 32'h0000_0013.
- Sub-module fetch_queue: a parameterised synchronous FIFO (width 64, depth QDEPTH) with push, pop, flush, count, and a registered head.

Test Plan:
- Reset release, 1-cycle memory, id_stall=0 -> imem_address sequence 4000_0060, ..64, ..68; if_pc follows the same values with matching instructions.
- id_stall=1 held for 6 cycles -> at most QDEPTH=2 responses are accepted; imem_read deasserts; if_pc stays constant; resuming delivers in order with no loss or duplication.
- branch_jal pulse to 4000_1000 while a 3-cycle-latency request to 4000_0070 is outstanding -> imem_address held until resp, that data is dropped, and the next request and if_pc are 4000_1000.
- jalr with jalr_target=4000_2003 coincident with imem_resp -> the response is discarded and the next fetch is 4000_2000.
- fetch_pc=FFFF_FFFC -> the next fetch address is 0000_0000.
- rst pulled low while BUSY -> all outputs are at reset values immediately (asynchronously); after release the first fetch is RESET_PC and a late imem_resp is not enqueued.
